// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file: default widths, XZR index and
// clear FSM state encodings.
package regfile_mp_pkg;
  localparam int WORDSIZE_DEF    = 64;
  localparam int REGADDRSIZE_DEF = 5;
  localparam int XZR             = 31;

  typedef logic [0:0] clr_state_t;
  localparam clr_state_t ST_IDLE  = 1'b0;
  localparam clr_state_t ST_CLEAR = 1'b1;
endpackage

// File: rtl/regfile_mp_clear_seq.sv
// Sequenced clear engine: sweeps every register index once, one per cycle, after a
// request seen while idle.
module regfile_clear_seq
  import regfile_mp_pkg::*;
#(
  parameter int ADDRW = REGADDRSIZE_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             clr_we,
  output logic [ADDRW-1:0] clr_idx
);
  clr_state_t       state;
  logic [ADDRW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (state == ST_IDLE) begin
      if (clr_req) begin
        state <= ST_CLEAR;
        cnt   <= '0;
      end
    end else begin
      // The counter rolls over to zero on the same edge the FSM drops back to idle.
      cnt <= cnt + 1'b1;
      if (cnt == {ADDRW{1'b1}}) state <= ST_IDLE;
    end
  end

  assign clr_busy = (state == ST_CLEAR);
  assign clr_we   = clr_busy;
  assign clr_idx  = cnt;
endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with pending scoreboard and sequenced clear.
// Optional same-cycle write-to-read bypass under REGFILE_WRITE_BYPASS_EN.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int WORDSIZE    = WORDSIZE_DEF,
  parameter int REGADDRSIZE = REGADDRSIZE_DEF,
  parameter int NREAD       = 2,
  parameter int HASZERO     = 1,
  parameter int ZEROREG     = XZR
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NREAD*REGADDRSIZE-1:0] rd_addr,
  output logic [NREAD*WORDSIZE-1:0]    rd_data,
  output logic [NREAD-1:0]             rd_pend,
  input  logic                         wr0_en,
  input  logic [REGADDRSIZE-1:0]       wr0_addr,
  input  logic [WORDSIZE-1:0]          wr0_data,
  input  logic                         wr1_en,
  input  logic [REGADDRSIZE-1:0]       wr1_addr,
  input  logic [WORDSIZE-1:0]          wr1_data,
  input  logic                         mark_en,
  input  logic [REGADDRSIZE-1:0]       mark_addr,
  input  logic                         clr_req,
  output logic                         clr_busy
);
  localparam int                     DEPTH = 1 << REGADDRSIZE;
  localparam logic [REGADDRSIZE-1:0] ZADDR = REGADDRSIZE'(ZEROREG);

  logic [WORDSIZE-1:0]    regs [DEPTH];
  logic [DEPTH-1:0]       pend;
  logic                   clr_we;
  logic [REGADDRSIZE-1:0] clr_idx;
  logic                   we0, we1, mk;

  regfile_clear_seq #(.ADDRW(REGADDRSIZE)) u_clear (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx)
  );

  assign we0 = wr0_en  && !clr_busy && !((HASZERO != 0) && (wr0_addr  == ZADDR));
  assign we1 = wr1_en  && !clr_busy && !((HASZERO != 0) && (wr1_addr  == ZADDR));
  assign mk  = mark_en && !clr_busy && !((HASZERO != 0) && (mark_addr == ZADDR));

  // Statement order encodes priority: port 1 over port 0, mark over write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pend <= '0;
    end else begin
      if (we0) begin
        regs[wr0_addr] <= wr0_data;
        pend[wr0_addr] <= 1'b0;
      end
      if (we1) begin
        regs[wr1_addr] <= wr1_data;
        pend[wr1_addr] <= 1'b0;
      end
      if (mk) pend[mark_addr] <= 1'b1;
      if (clr_we) begin
        regs[clr_idx] <= '0;
        pend[clr_idx] <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
    logic [REGADDRSIZE-1:0] a;
    logic [WORDSIZE-1:0]    d;
    logic                   p;
    logic                   is_zero;

    assign a       = rd_addr[gi*REGADDRSIZE +: REGADDRSIZE];
    assign is_zero = (HASZERO != 0) && (a == ZADDR);

    always_comb begin
      d = regs[a];
      p = pend[a];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (!clr_busy && !is_zero) begin
        if (wr1_en && wr1_addr == a) begin
          d = wr1_data;
          p = mark_en && (mark_addr == a);
        end else if (wr0_en && wr0_addr == a) begin
          d = wr0_data;
          p = mark_en && (mark_addr == a);
        end
      end
`endif
      if (is_zero) begin
        d = '0;
        p = 1'b0;
      end
    end

    assign rd_data[gi*WORDSIZE +: WORDSIZE] = d;
    assign rd_pend[gi]                      = p;
  end
endmodule
